// File: rtl/adder_wide_sequencer_pkg.sv
// Shared definitions for the multi-precision add/sub sequencer and its word adder:
// request op codes, adder control encodings and the sequencer state enum.
package adder_wide_sequencer_pkg;

   typedef enum logic [1:0] {
      OP_ADD  = 2'b00,
      OP_ADDC = 2'b01,
      OP_SUB  = 2'b10
   } op_e;

   localparam logic [1:0] ADDER_CTL_ADD  = 2'b00;
   localparam logic [1:0] ADDER_CTL_ADDC = 2'b01;
   localparam logic [1:0] ADDER_CTL_SUB  = 2'b10;

   localparam logic [3:0] CMP_HOLD = 4'b1111;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   // Request code 2'b11 is an alias of plain ADD.
   function automatic op_e decode_op(input logic [1:0] code);
      case (code)
         2'b01:   return OP_ADDC;
         2'b10:   return OP_SUB;
         default: return OP_ADD;
      endcase
   endfunction

   function automatic int idx_width(input int words);
      return (words > 1) ? $clog2(words) : 1;
   endfunction

endpackage

// File: rtl/adder_wide_sequencer_if.sv
// Request/response channels plus the word-adder bus of the wide add/sub sequencer.
// slave = sequencer side, master = requester/adder side.
interface adder_wide_sequencer_if #(
   parameter int WORDS = 2
) ();
   localparam int W = 32 * WORDS;

   logic          req_valid;
   logic          req_ready;
   logic [1:0]    req_op;
   logic [W-1:0]  req_a;
   logic [W-1:0]  req_b;
   logic          req_carry_in;

   logic          rsp_valid;
   logic          rsp_ready;
   logic [W-1:0]  rsp_result;
   logic          rsp_carry;
   logic          rsp_overflow;

   logic          add_stall;
   logic          add_carry_in;
   logic [1:0]    add_control;
   logic [3:0]    add_compare_ctrl;
   logic [31:0]   add_operant_a;
   logic [31:0]   add_operant_b;
   logic [31:0]   add_result;
   logic          add_carry_out;
   logic          add_overflow;

   modport slave (
      input  req_valid, req_op, req_a, req_b, req_carry_in, rsp_ready,
             add_result, add_carry_out, add_overflow,
      output req_ready, rsp_valid, rsp_result, rsp_carry, rsp_overflow,
             add_stall, add_carry_in, add_control, add_compare_ctrl,
             add_operant_a, add_operant_b
   );

   modport master (
      output req_valid, req_op, req_a, req_b, req_carry_in, rsp_ready,
             add_result, add_carry_out, add_overflow,
      input  req_ready, rsp_valid, rsp_result, rsp_carry, rsp_overflow,
             add_stall, add_carry_in, add_control, add_compare_ctrl,
             add_operant_a, add_operant_b
   );

endinterface

// File: rtl/adder_wide_sequencer_adder.sv
// 32-bit word adder driven by the sequencer: combinational result, carry/overflow/compare
// flag registered and frozen while stalled. control[1] inverts B and forces carry-in to 1.
module adder_wide_sequencer_adder
   import adder_wide_sequencer_pkg::*;
(
   input  logic        clock,
   input  logic        reset,
   input  logic        i_stall,
   input  logic        i_carry_in,
   input  logic [1:0]  i_control,
   input  logic [3:0]  i_compare_ctrl,
   input  logic [31:0] i_operant_a,
   input  logic [31:0] i_operant_b,
   output logic [31:0] o_result,
   output logic        o_carry_out,
   output logic        o_overflow,
   output logic        o_flag
);

   localparam logic [3:0] CMP_ZERO  = 4'b0000;
   localparam logic [3:0] CMP_CARRY = 4'b0001;
   localparam logic [3:0] CMP_NEG   = 4'b0010;
   localparam logic [3:0] CMP_OVF   = 4'b0011;

   logic [31:0] w_b_eff;
   logic        w_cin_eff;
   logic [32:0] w_sum;
   logic        w_ovf;

   logic        r_carry;
   logic        r_ovf;
   logic        r_flag;

   always_comb begin
      w_b_eff   = i_control[1] ? ~i_operant_b : i_operant_b;
      w_cin_eff = i_control[1] ? 1'b1 : (i_control[0] & i_carry_in);
      w_sum     = {1'b0, i_operant_a} + {1'b0, w_b_eff} + {32'd0, w_cin_eff};
      w_ovf     = (i_operant_a[31] == w_b_eff[31]) && (w_sum[31] != i_operant_a[31]);
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_carry <= 1'b0;
         r_ovf   <= 1'b0;
         r_flag  <= 1'b0;
      end else if (!i_stall) begin
         r_carry <= w_sum[32];
         r_ovf   <= w_ovf;
         // CMP_HOLD and any other unlisted code keep the flag unchanged
         case (i_compare_ctrl)
            CMP_ZERO:  r_flag <= (w_sum[31:0] == 32'd0);
            CMP_CARRY: r_flag <= w_sum[32];
            CMP_NEG:   r_flag <= w_sum[31];
            CMP_OVF:   r_flag <= w_ovf;
            default:   r_flag <= r_flag;
         endcase
      end
   end

   assign o_result    = w_sum[31:0];
   assign o_carry_out = r_carry;
   assign o_overflow  = r_ovf;
   assign o_flag      = r_flag;

endmodule

// File: rtl/adder_wide_sequencer.sv
// Multi-precision add/sub: runs a WORDS*32-bit operation through one external 32-bit adder,
// low word first, chaining the adder's registered carry-out into the next word.
module adder_wide_sequencer
   import adder_wide_sequencer_pkg::*;
#(
   parameter int WORDS = 2
) (
   input  logic                  clock,
   input  logic                  reset,
   adder_wide_sequencer_if.slave bus
);

   localparam int W     = 32 * WORDS;
   localparam int IDX_W = idx_width(WORDS);

   state_e           r_state;
   state_e           w_state_next;
   logic [IDX_W-1:0] r_idx;
   logic [W-1:0]     r_a;
   logic [W-1:0]     r_b;
   op_e              r_op;
   logic             r_cin;

   logic [31:0]      w_a_words [WORDS];
   logic [31:0]      w_b_words [WORDS];
   logic [W-1:0]     w_result;
   logic             w_accept;
   logic             w_last_word;

   logic             w_req_ready;
   logic             w_rsp_valid;
   logic             w_stall;
   logic [1:0]       w_ctl;
   logic             w_cin;
   logic [31:0]      w_opa;
   logic [31:0]      w_opb;

   assign w_accept    = (r_state == ST_IDLE) && bus.req_valid;
   assign w_last_word = (r_idx == IDX_W'(WORDS - 1));

   genvar gi;
   generate
      for (gi = 0; gi < WORDS; gi++) begin : g_word
         logic [31:0] r_word;

         assign w_a_words[gi] = r_a[gi*32 +: 32];
         assign w_b_words[gi] = r_b[gi*32 +: 32];

         always_ff @(posedge clock) begin
            if (reset) begin
               r_word <= 32'd0;
            end else if ((r_state == ST_RUN) && (r_idx == IDX_W'(gi))) begin
               r_word <= bus.add_result;
            end
         end

         assign w_result[gi*32 +: 32] = r_word;
      end
   endgenerate

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_a   <= '0;
         r_b   <= '0;
         r_op  <= OP_ADD;
         r_cin <= 1'b0;
         r_idx <= '0;
      end else if (w_accept) begin
         r_a   <= bus.req_a;
         r_b   <= bus.req_b;
         r_op  <= decode_op(bus.req_op);
         r_cin <= bus.req_carry_in;
         r_idx <= '0;
      end else if (r_state == ST_RUN) begin
         r_idx <= w_last_word ? '0 : r_idx + 1'b1;
      end
   end

   always_comb begin
      w_state_next = r_state;
      w_req_ready  = 1'b0;
      w_rsp_valid  = 1'b0;
      w_stall      = 1'b1;
      w_ctl        = ADDER_CTL_ADD;
      w_cin        = 1'b0;
      w_opa        = 32'd0;
      w_opb        = 32'd0;
      case (r_state)
         ST_IDLE: begin
            w_req_ready = 1'b1;
            if (bus.req_valid) begin
               w_state_next = ST_RUN;
            end
         end
         ST_RUN: begin
            w_stall = 1'b0;
            w_opa   = w_a_words[r_idx];
            if (r_idx == '0) begin
               w_opb = w_b_words[r_idx];
               case (r_op)
                  OP_ADDC: begin
                     w_ctl = ADDER_CTL_ADDC;
                     w_cin = r_cin;
                  end
                  OP_SUB:  w_ctl = ADDER_CTL_SUB;
                  default: w_ctl = ADDER_CTL_ADD;
               endcase
            end else begin
               // Upper words always use carry-chain mode, so SUB inverts B here
               w_ctl = ADDER_CTL_ADDC;
               w_cin = bus.add_carry_out;
               w_opb = (r_op == OP_SUB) ? ~w_b_words[r_idx] : w_b_words[r_idx];
            end
            if (w_last_word) begin
               w_state_next = ST_DONE;
            end
         end
         ST_DONE: begin
            w_rsp_valid = 1'b1;
            if (bus.rsp_ready) begin
               w_state_next = ST_IDLE;
            end
         end
         default: w_state_next = ST_IDLE;
      endcase
   end

   assign bus.req_ready        = w_req_ready;
   assign bus.rsp_valid        = w_rsp_valid;
   assign bus.rsp_result       = w_result;
   // Adder flags are frozen by add_stall outside RUN, so they hold through DONE
   assign bus.rsp_carry        = bus.add_carry_out;
   assign bus.rsp_overflow     = bus.add_overflow;
   assign bus.add_stall        = w_stall;
   assign bus.add_carry_in     = w_cin;
   assign bus.add_control      = w_ctl;
   assign bus.add_compare_ctrl = CMP_HOLD;
   assign bus.add_operant_a    = w_opa;
   assign bus.add_operant_b    = w_opb;

endmodule
